// File: rtl/piece_move_animator.sv
// piece_move_animator: slides a chess sprite origin from one board square to another, one step per frame
module piece_move_animator #(
  parameter int BOARD_X0 = 100,
  parameter int BOARD_Y0 = 20,
  parameter int SQUARE   = 55,
  parameter int STEP     = 5
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [2:0] from_col,
  input  logic [2:0] from_row,
  input  logic [2:0] to_col,
  input  logic [2:0] to_row,
  output logic [9:0] offsetX,
  output logic [9:0] offsetY,
  output logic       sprite_en,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, LOAD, MOVE, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] fc_q, fr_q, tc_q, tr_q, fc_d, fr_d, tc_d, tr_d;
  logic [9:0] x_q, y_q, tx_q, ty_q, x_d, y_d, tx_d, ty_d;
  logic en_q, busy_q, done_q, en_d, busy_d, done_d;
  function automatic logic [9:0] approach(input logic [9:0] cur, input logic [9:0] tgt);
    logic signed [10:0] d;
    logic [10:0] m;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    m = d[10] ? 11'(-d) : 11'(d);
    m = m > 11'(STEP) ? 11'(STEP) : m;
    return d[10] ? cur - m[9:0] : cur + m[9:0];
  endfunction
  always_comb begin
    state_d = state_q;
    fc_d = fc_q;
    fr_d = fr_q;
    tc_d = tc_q;
    tr_d = tr_q;
    x_d = x_q;
    y_d = y_q;
    tx_d = tx_q;
    ty_d = ty_q;
    case (state_q)
      IDLE: if (start) begin
        fc_d = from_col;
        fr_d = from_row;
        tc_d = to_col;
        tr_d = to_row;
        state_d = LOAD;
      end
      LOAD: begin
        x_d = 10'(BOARD_X0 + int'(fc_q) * SQUARE);
        y_d = 10'(BOARD_Y0 + int'(fr_q) * SQUARE);
        tx_d = 10'(BOARD_X0 + int'(tc_q) * SQUARE);
        ty_d = 10'(BOARD_Y0 + int'(tr_q) * SQUARE);
        state_d = MOVE;
      end
      MOVE: if (x_q == tx_q && y_q == ty_q) state_d = DONE;
      else if (frame_tick) begin
        x_d = approach(x_q, tx_q);
        y_d = approach(y_q, ty_q);
      end
      DONE: state_d = IDLE;
    endcase
    en_d = state_d == MOVE || state_d == DONE;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= IDLE;
      fc_q <= '0;
      fr_q <= '0;
      tc_q <= '0;
      tr_q <= '0;
      x_q <= 10'(BOARD_X0);
      y_q <= 10'(BOARD_Y0);
      tx_q <= 10'(BOARD_X0);
      ty_q <= 10'(BOARD_Y0);
      en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q <= fc_d;
      fr_q <= fr_d;
      tc_q <= tc_d;
      tr_q <= tr_d;
      x_q <= x_d;
      y_q <= y_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
      en_q <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign offsetX = x_q;
  assign offsetY = y_q;
  assign sprite_en = en_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_piece_move_animator.sv
// tb_piece_move_animator: scoreboard bench checking sprite motion, done timing, busy-start rejection and reset abort
module tb_piece_move_animator;
  logic vga_clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic [2:0] from_col = '0, from_row = '0, to_col = '0, to_row = '0;
  logic [9:0] offsetX, offsetY;
  logic sprite_en, busy, done;
  int total = 0, bad = 0, done_cnt = 0;
  typedef struct {int x; int y;} pos_t;
  pos_t sb[$];
  piece_move_animator dut (
    .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .from_col(from_col), .from_row(from_row), .to_col(to_col), .to_row(to_row),
    .offsetX(offsetX), .offsetY(offsetY), .sprite_en(sprite_en), .busy(busy), .done(done)
  );
  always #5 vga_clk = ~vga_clk;
  always @(negedge vga_clk) if (done) done_cnt++;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge vga_clk);
    #1;
  endtask
  task automatic push(input int x, input int y);
    pos_t p;
    p.x = x;
    p.y = y;
    sb.push_back(p);
  endtask
  task automatic pop_chk(input string tag);
    pos_t p;
    if (sb.size() == 0) begin
      chk({tag, "_empty"}, 0, 1);
      return;
    end
    p = sb.pop_front();
    chk({tag, "_x"}, int'(offsetX), p.x);
    chk({tag, "_y"}, int'(offsetY), p.y);
  endtask
  function automatic int appr(input int c, input int t);
    if (t - c > 5) return c + 5;
    if (c - t > 5) return c - 5;
    return t;
  endfunction
  task automatic move(input int fc, input int fr, input int tc, input int tr, input int gap,
                      input int exp_ticks, input int start2_at, input int abort_at, input bit load_tick);
    int cx, cy, tx, ty, n, d0;
    cx = 100 + fc * 55;
    cy = 20 + fr * 55;
    tx = 100 + tc * 55;
    ty = 20 + tr * 55;
    d0 = done_cnt;
    from_col = 3'(fc);
    from_row = 3'(fr);
    to_col = 3'(tc);
    to_row = 3'(tr);
    start = 1'b1;
    cyc;
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_en", sprite_en, 0);
    frame_tick = load_tick;
    push(cx, cy);
    cyc;
    frame_tick = 1'b0;
    pop_chk("src");
    chk("move_en", sprite_en, 1);
    n = 0;
    while ((cx != tx || cy != ty) && n < 100) begin
      repeat (gap - 1) begin
        cyc;
        chk("hold_x", offsetX, cx);
        chk("hold_y", offsetY, cy);
      end
      frame_tick = 1'b1;
      if (n + 1 == start2_at) begin
        start = 1'b1;
        from_col = 3'd2;
        from_row = 3'd2;
        to_col = 3'd0;
        to_row = 3'd0;
      end
      cx = appr(cx, tx);
      cy = appr(cy, ty);
      n++;
      push(cx, cy);
      cyc;
      frame_tick = 1'b0;
      start = 1'b0;
      pop_chk("tick");
      if (n == abort_at) begin
        reset = 1'b1;
        cyc;
        reset = 1'b0;
        chk("abort_x", offsetX, 100);
        chk("abort_y", offsetY, 20);
        chk("abort_busy", busy, 0);
        chk("abort_en", sprite_en, 0);
        chk("abort_done_cnt", done_cnt - d0, 0);
        return;
      end
    end
    chk("ticks", n, exp_ticks);
    chk("pre_done", done, 0);
    push(tx, ty);
    cyc;
    chk("done", done, 1);
    chk("done_en", sprite_en, 1);
    pop_chk("dst");
    cyc;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_en", sprite_en, 0);
    chk("idle_x", offsetX, tx);
    chk("done_cnt", done_cnt - d0, 1);
  endtask
  initial begin
    repeat (3) cyc;
    chk("rst_x", offsetX, 100);
    chk("rst_y", offsetY, 20);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", sprite_en, 0);
    reset = 1'b0;
    cyc;
    move(0, 0, 3, 0, 10, 33, 0, 0, 1'b0);
    move(1, 0, 2, 2, 3, 22, 0, 0, 1'b1);
    move(4, 4, 4, 4, 1, 0, 0, 0, 1'b0);
    move(0, 0, 7, 7, 2, 77, 5, 0, 1'b0);
    move(0, 0, 7, 0, 2, 77, 0, 10, 1'b0);
    move(4, 4, 4, 4, 1, 0, 0, 0, 1'b0);
    move(2, 1, 5, 3, 1, 33, 0, 0, 1'b0);
    move(6, 5, 1, 2, 1, 55, 0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
